memory_word_loader: RTL and testbench

- Byte-serial read sequencer that fetches 1, 2 or 4 consecutive bytes from the byte-wide memory and assembles them into a 32-bit word for the DR path.
- It is the read-side counterpart of the ALU system's byte-slice output (MuxCOut). That path takes a 32-bit ALU result apart into bytes for memory writes; this block puts memory bytes back together into a 32-bit operand.
- It sits between the memory read port and the DR load input, and is driven by a start/done handshake from the control unit.

---
 rtl/memory_word_loader_if.sv | 31 +++
 rtl/memory_word_loader.sv | 136 +++++++++++++
 tb/tb_memory_word_loader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_word_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_word_loader_if
// Brief    : Control, memory-read and DR-load signals of the byte-serial loader.
// Revision : 1.0
// ============================================================================
interface memory_word_loader_if #(
  parameter int ADDR_W = 16
);
  logic              Start;
  logic [ADDR_W-1:0] BaseAddr;
  logic [1:0]        Size;
  logic              SignExt;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemRead;
  logic [7:0]        MemData;
  logic [31:0]       DROut;
  logic              Busy;
  logic              Done;

  modport slave (
    input  Start, BaseAddr, Size, SignExt, MemData,
    output MemAddr, MemRead, DROut, Busy, Done
  );

  modport master (
    output Start, BaseAddr, Size, SignExt, MemData,
    input  MemAddr, MemRead, DROut, Busy, Done
  );
endinterface
`default_nettype wire

// File: rtl/memory_word_loader.sv
`default_nettype none
// ============================================================================
// Module   : memory_word_loader
// Brief    : Fetches 1, 2 or 4 consecutive memory bytes and assembles them
//            into a sign/zero-extended 32-bit word for the DR path.
// Revision : 1.0
// ============================================================================
module memory_word_loader #(
  parameter int ADDR_W     = 16,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  memory_word_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] base_addr;
  logic [1:0]        size;
  logic              sign_ext;
  logic [1:0]        index;
  logic [31:0]       assembly;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic [31:0]       dr_out;
  logic              done;

  logic              accept;
  logic              finish;
  logic [1:0]        last_index;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] addr_next;
  logic [31:0]       assembly_next;
  logic [31:0]       extended;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) begin
          accept     = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        state_next = CAPTURE;
      end
      CAPTURE: begin
        if (index == last_index) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = READ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Byte lane for the incoming byte; big-endian mirrors it within the loaded size.
  always_comb begin
    last_index    = (size == 2'b00) ? 2'd0 : ((size == 2'b01) ? 2'd1 : 2'd3);
    lane          = BIG_ENDIAN ? (last_index - index) : index;
    assembly_next = assembly;
    assembly_next[{lane, 3'b000} +: 8] = bus.MemData;
    case (size)
      2'b00:   extended = {{24{sign_ext & assembly_next[7]}},  assembly_next[7:0]};
      2'b01:   extended = {{16{sign_ext & assembly_next[15]}}, assembly_next[15:0]};
      default: extended = assembly_next;
    endcase
    addr_next = accept ? bus.BaseAddr
                       : (base_addr + ADDR_W'(index) + ADDR_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      base_addr <= '0;
      size      <= 2'b00;
      sign_ext  <= 1'b0;
      index     <= 2'd0;
      assembly  <= 32'd0;
      mem_addr  <= '0;
      mem_read  <= 1'b0;
      dr_out    <= 32'd0;
      done      <= 1'b0;
    end else begin
      mem_read <= (state_next == READ);
      done     <= finish;
      if (accept) begin
        base_addr <= bus.BaseAddr;
        size      <= bus.Size;
        sign_ext  <= bus.SignExt;
        index     <= 2'd0;
        assembly  <= 32'd0;
      end
      if (state_next == READ) begin
        mem_addr <= addr_next;
      end
      if (state == CAPTURE) begin
        assembly <= assembly_next;
        if (finish) begin
          dr_out <= extended;
        end else begin
          index <= index + 2'd1;
        end
      end
    end
  end

  assign bus.MemAddr = mem_addr;
  assign bus.MemRead = mem_read;
  assign bus.DROut   = dr_out;
  assign bus.Busy    = (state != IDLE);
  assign bus.Done    = done;

endmodule
`default_nettype wire

// File: tb/tb_memory_word_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_word_loader
// Brief    : Drives a little-endian and a big-endian loader in lockstep against
//            a byte-array memory and an arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_memory_word_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] base;
  logic [1:0]  size;
  logic        sext;
  logic [7:0]  md0;
  logic [7:0]  md1;
  logic [7:0]  mem [0:65535];

  int checks   = 0;
  int failures = 0;
  int viol     = 0;
  int ndone0   = 0;
  logic [15:0] addrq0[$];
  logic [15:0] addrq1[$];

  memory_word_loader_if #(.ADDR_W(16)) bus0 ();
  memory_word_loader_if #(.ADDR_W(16)) bus1 ();

  assign bus0.Start    = start;
  assign bus0.BaseAddr = base;
  assign bus0.Size     = size;
  assign bus0.SignExt  = sext;
  assign bus0.MemData  = md0;
  assign bus1.Start    = start;
  assign bus1.BaseAddr = base;
  assign bus1.Size     = size;
  assign bus1.SignExt  = sext;
  assign bus1.MemData  = md1;

  memory_word_loader #(.ADDR_W(16), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  memory_word_loader #(.ADDR_W(16), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers one cycle after a read; other cycles carry garbage.
  always @(posedge clk) begin
    md0 <= bus0.MemRead ? mem[bus0.MemAddr] : 8'($urandom);
    md1 <= bus1.MemRead ? mem[bus1.MemAddr] : 8'($urandom);
  end

  logic        prd0 = 1'b0, prd1 = 1'b0, pdn0 = 1'b0;
  logic [31:0] pdr0 = 32'd0, pdr1 = 32'd0;
  always @(negedge clk) begin
    if (bus0.MemRead === 1'b1) addrq0.push_back(bus0.MemAddr);
    if (bus1.MemRead === 1'b1) addrq1.push_back(bus1.MemAddr);
    if (bus0.MemRead === 1'b1 && (prd0 || bus0.Busy !== 1'b1)) viol++;
    if (bus1.MemRead === 1'b1 && (prd1 || bus1.Busy !== 1'b1)) viol++;
    if (bus0.Busy === 1'b1 && bus0.DROut !== pdr0) viol++;
    if (bus1.Busy === 1'b1 && bus1.DROut !== pdr1) viol++;
    if (bus0.Done === 1'b1 && (pdn0 || bus0.Busy !== 1'b0)) viol++;
    if (bus0.Done === 1'b1) ndone0++;
    prd0 = (bus0.MemRead === 1'b1);
    prd1 = (bus1.MemRead === 1'b1);
    pdn0 = (bus0.Done === 1'b1);
    pdr0 = bus0.DROut;
    pdr1 = bus1.DROut;
  end

  function automatic logic [31:0] model(input logic [15:0] b, input logic [1:0] s,
                                        input logic x, input bit be);
    int          n;
    logic [31:0] w;
    logic [15:0] a;
    n = (s == 2'b00) ? 1 : ((s == 2'b01) ? 2 : 4);
    w = 32'd0;
    for (int i = 0; i < n; i++) begin
      a = b + 16'(i);
      w[8 * (be ? (n - 1 - i) : i) +: 8] = mem[a];
    end
    if (n < 4 && x && w[8 * n - 1]) w = w | ~((32'd1 << (8 * n)) - 32'd1);
    return w;
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic start_load(input logic [15:0] b, input logic [1:0] s, input logic x);
    start = 1'b1; base = b; size = s; sext = x;
    addrq0.delete();
    addrq1.delete();
    @(negedge clk);
    start = 1'b0; base = 16'($urandom); size = 2'($urandom); sext = 1'($urandom);
  endtask

  task automatic wait_done(inout int lat, output logic [31:0] d0, output logic [31:0] d1,
                           output logic dn1);
    while (bus0.Done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    d0 = bus0.DROut; d1 = bus1.DROut; dn1 = bus1.Done;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus0.DROut !== 32'd0 || bus1.DROut !== 32'd0) begin
      failures++; $display("FAIL reset_drout: got %h/%h want 0", bus0.DROut, bus1.DROut);
    end
    checks++;
    if ({bus0.Busy, bus0.Done, bus0.MemRead} !== 3'b000 || bus0.MemAddr !== 16'h0000) begin
      failures++;
      $display("FAIL reset_ctrl: busy/done/rd=%b addr=%h want 000/0000",
               {bus0.Busy, bus0.Done, bus0.MemRead}, bus0.MemAddr);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word;
    int lat; logic [31:0] d0, d1; logic dn1;
    mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22; mem[16'h0012] = 8'h33; mem[16'h0013] = 8'h84;
    start_load(16'h0010, 2'b10, 1'b1);
    lat = 0;
    wait_done(lat, d0, d1, dn1);
    checks++;
    if (lat != 8 || dn1 !== 1'b1) begin
      failures++; $display("FAIL word_latency: got %0d (be done %b) want 8", lat, dn1);
    end
    checks++;
    if (d0 !== 32'h84332211) begin failures++; $display("FAIL word_le: got %h want 84332211", d0); end
    checks++;
    if (d1 !== 32'h11223384) begin failures++; $display("FAIL word_be: got %h want 11223384", d1); end
    checks++;
    if (addrq0.size() != 4 || addrq1.size() != 4) begin
      failures++; $display("FAIL word_nreads: got %0d/%0d want 4", addrq0.size(), addrq1.size());
    end
    for (int i = 0; i < addrq0.size() && i < 4; i++) begin
      checks++;
      if (addrq0[i] !== 16'h0010 + 16'(i)) begin
        failures++; $display("FAIL word_addr%0d: got %h want %h", i, addrq0[i], 16'h0010 + 16'(i));
      end
    end
  endtask

  task automatic test_byte_half;
    int lat; logic [31:0] d0, d1; logic dn1;
    logic [1:0]  ts [4]   = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic [15:0] tb_ [4]  = '{16'h0013, 16'h0013, 16'h0012, 16'h0012};
    logic        tx [4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] ele [4]  = '{32'hFFFFFF84, 32'h00000084, 32'h00008433, 32'hFFFF8433};
    logic [31:0] ebe [4]  = '{32'hFFFFFF84, 32'h00000084, 32'h00003384, 32'h00003384};
    int          elat [4] = '{2, 2, 4, 4};
    for (int t = 0; t < 4; t++) begin
      start_load(tb_[t], ts[t], tx[t]);
      lat = 0;
      wait_done(lat, d0, d1, dn1);
      checks++;
      if (lat != elat[t]) begin
        failures++; $display("FAIL short%0d_latency: got %0d want %0d", t, lat, elat[t]);
      end
      checks++;
      if (d0 !== ele[t]) begin failures++; $display("FAIL short%0d_le: got %h want %h", t, d0, ele[t]); end
      checks++;
      if (d1 !== ebe[t]) begin failures++; $display("FAIL short%0d_be: got %h want %h", t, d1, ebe[t]); end
    end
  endtask

  task automatic test_wrap;
    int lat; logic [31:0] d0, d1; logic dn1;
    mem[16'hFFFE] = 8'hAA; mem[16'hFFFF] = 8'hBB; mem[16'h0000] = 8'hCC; mem[16'h0001] = 8'hDD;
    start_load(16'hFFFE, 2'b11, 1'b0);
    lat = 0;
    wait_done(lat, d0, d1, dn1);
    checks++;
    if (d0 !== 32'hDDCCBBAA || d1 !== 32'hAABBCCDD) begin
      failures++; $display("FAIL wrap_data: got %h/%h want DDCCBBAA/AABBCCDD", d0, d1);
    end
    checks++;
    if (addrq1.size() != 4 || addrq1[2] !== 16'h0000 || addrq1[1] !== 16'hFFFF || addrq1[3] !== 16'h0001) begin
      failures++; $display("FAIL wrap_addr: got %p want FFFE FFFF 0000 0001", addrq1);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] d0, d1; logic dn1;
    start_load(16'h0010, 2'b10, 1'b0);
    lat = 0;
    repeat (2) begin @(negedge clk); lat++; end
    start = 1'b1; base = 16'h0040; size = 2'b00; sext = 1'b1;
    @(negedge clk); lat++;
    start = 1'b0;
    wait_done(lat, d0, d1, dn1);
    checks++;
    if (lat != 8 || d0 !== 32'h84332211 || d1 !== 32'h11223384) begin
      failures++; $display("FAIL ignore_start: lat %0d data %h/%h want 8 84332211/11223384", lat, d0, d1);
    end
    checks++;
    if (addrq0.size() != 4 || addrq0[3] !== 16'h0013) begin
      failures++; $display("FAIL ignore_addr: got %p want 0010..0013", addrq0);
    end
    start_load(16'h0013, 2'b00, 1'b1);
    checks++;
    if (bus0.MemRead !== 1'b1 || bus0.MemAddr !== 16'h0013) begin
      failures++; $display("FAIL b2b_read: rd %b addr %h want 1 0013", bus0.MemRead, bus0.MemAddr);
    end
    lat = 0;
    wait_done(lat, d0, d1, dn1);
    checks++;
    if (lat != 2 || d0 !== 32'hFFFFFF84) begin
      failures++; $display("FAIL b2b_result: lat %0d data %h want 2 FFFFFF84", lat, d0);
    end
  endtask

  task automatic test_reset_midload;
    int lat; int n; logic [31:0] d0, d1; logic dn1;
    start_load(16'hFFFE, 2'b10, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus0.DROut !== 32'd0 || bus1.DROut !== 32'd0 || bus0.Busy !== 1'b0 ||
        bus0.Done !== 1'b0 || bus0.MemRead !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state: dr %h/%h busy %b done %b rd %b want 0",
               bus0.DROut, bus1.DROut, bus0.Busy, bus0.Done, bus0.MemRead);
    end
    rst = 1'b1;
    n = ndone0;
    repeat (10) @(negedge clk);
    checks++;
    if (ndone0 != n || bus0.Busy !== 1'b0) begin
      failures++; $display("FAIL midreset_nodone: done pulses %0d busy %b want 0 0", ndone0 - n, bus0.Busy);
    end
    start_load(16'h0010, 2'b01, 1'b1);
    lat = 0;
    wait_done(lat, d0, d1, dn1);
    checks++;
    if (lat != 4 || d0 !== 32'h00002211 || d1 !== 32'h00001122) begin
      failures++; $display("FAIL midreset_after: lat %0d data %h/%h want 4 00002211/00001122", lat, d0, d1);
    end
  endtask

  task automatic test_random;
    int lat; int n; logic [31:0] d0, d1; logic dn1;
    logic [15:0] b; logic [1:0] s; logic x;
    for (int k = 0; k < 40; k++) begin
      b = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
      s = 2'($urandom); x = 1'($urandom);
      for (int i = 0; i < 4; i++) mem[b + 16'(i)] = 8'($urandom);
      n = (s == 2'b00) ? 1 : ((s == 2'b01) ? 2 : 4);
      start_load(b, s, x);
      lat = 0;
      wait_done(lat, d0, d1, dn1);
      checks++;
      if (lat != 2 * n) begin failures++; $display("FAIL rnd%0d_latency: got %0d want %0d", k, lat, 2 * n); end
      checks++;
      if (d0 !== model(b, s, x, 1'b0)) begin
        failures++; $display("FAIL rnd%0d_le: got %h want %h", k, d0, model(b, s, x, 1'b0));
      end
      checks++;
      if (d1 !== model(b, s, x, 1'b1)) begin
        failures++; $display("FAIL rnd%0d_be: got %h want %h", k, d1, model(b, s, x, 1'b1));
      end
      checks++;
      if (addrq0.size() != n || addrq0[addrq0.size() - 1] !== b + 16'(n - 1)) begin
        failures++; $display("FAIL rnd%0d_addr: got %p want %0d reads from %h", k, addrq0, n, b);
      end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_protocol;
    checks++;
    if (viol != 0) begin
      failures++; $display("FAIL protocol: got %0d violations want 0", viol);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; base = 16'h0000; size = 2'b00; sext = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_word();
    test_byte_half();
    test_wrap();
    test_back_to_back();
    test_reset_midload();
    test_random();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
